reflector_param: RTL and testbench
==================================

# reflector_param

Parametrised, handshaked successor to the fixed 26-letter reflector used by the Enigma datapath. It holds a runtime-loadable wiring table for an alphabet of `N_SYM` symbols. It performs one forward or inverse lookup per cycle through a single registered output stage with valid/ready flow control. An optional involution checker validates the loaded wiring before lookups are allowed. The block sits between the last rotor on the outbound path and the first rotor on the return path.

## Interface
- `N_SYM`, default 26: alphabet size. Legal range 2..256; must be even when the check is enabled.
- `SYM_W`, default 8: symbol width in bits.
- `BASE`, default 8'h41 ('A'): code of symbol index 0.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `cfg_start` input, 1 bit: pulse that begins a table load.
- `cfg_valid` input, 1 bit: a wiring entry is present on `cfg_data`.
- `cfg_data` input, `SYM_W` bits: output symbol for the current entry index. Entries are sent in order: index 0, then 1, and so on.
- `cfg_ready` output, 1 bit: the block is accepting entries (state LOAD).
- `cfg_done` output, 1 bit: one-cycle pulse on entry to RUN.
- `cfg_err` output, 1 bit: high while in ERR.
- `in_valid`, `in_ready`, 1 bit each: input handshake.
- `in_sym` input, `SYM_W` bits: symbol to reflect.
- `in_inv` input, 1 bit: 0 selects forward table, 1 selects inverse table.
- `out_valid` output, 1 bit; `out_ready` input, 1 bit: output handshake.
- `out_sym` output, `SYM_W` bits: reflected symbol.
- `out_err` output, 1 bit: the input was out of range.

## Operation
- Tables: `fwd[N_SYM]` and `inv[N_SYM]`. Each entry is `ceil(log2 N_SYM)` bits and stores an index, not a code.
- States: UNCFG (reset), LOAD, CHECK, RUN, ERR.
- `cfg_start` is honoured in UNCFG, RUN and ERR; it moves the block to LOAD. It is ignored in LOAD and CHECK.
- Entry counter `cnt` is cleared on entry to LOAD.
- LOAD: an entry is accepted when `cfg_valid && cfg_ready`.
  - Compute `d = cfg_data - BASE` in `SYM_W` bits, unsigned.
  - If `d >= N_SYM`, go to ERR.
  - Otherwise write `fwd[cnt] <= d` and `inv[d] <= cnt`, then increment `cnt`.
  - After the entry with `cnt == N_SYM-1` is accepted, go to CHECK (macro defined) or RUN (macro undefined).
- CHECK: scan `k = 0..N_SYM-1`, one index per cycle.
  - Fail if `fwd[fwd[k]] != k` or `fwd[k] == k`.
  - Any failure goes to ERR. Completing the scan goes to RUN.
- RUN: a lookup is accepted when `in_valid && in_ready`.
  - Compute `i = in_sym - BASE`.
  - If `i < N_SYM`: `out_sym <= BASE + (in_inv ? inv[i] : fwd[i])` and `out_err <= 0`.
  - Otherwise: `out_sym <= in_sym` and `out_err <= 1`.
- `in_ready = (state == RUN) && (!out_valid || out_ready)`.
- `out_valid` stays high, with `out_sym` and `out_err` stable, until `out_ready` is sampled high. Leaving RUN does not drop a held output.
- Duplicate entries are not flagged when the check is disabled; the last write to `inv` wins.

## Timing
- Reset values:
  - State UNCFG.
  - `cfg_ready`, `cfg_done`, `cfg_err`, `in_ready`, `out_valid` and `out_err` are all 0.
  - `out_sym` is 0 and `cnt` is 0.
  - Table contents are don't-care.
- `reset_n` low in any cycle, including mid-LOAD or mid-CHECK, returns the block to UNCFG at the next edge and discards the partial table.
- `cfg_start` sampled at edge t: `cfg_ready` is high from t+1.
- Last entry accepted at edge L:
  - With the check: CHECK occupies L+1..L+N_SYM; RUN and the `cfg_done` pulse are at L+N_SYM+1.
  - Without the check: RUN and `cfg_done` are at L+1.
- Lookup latency is 1 cycle: input accepted at edge t gives `out_valid` at t+1.
- Throughput is 1 lookup per cycle while `out_ready` is held at 1.
- Output accepted and new input accepted at the same edge: the output register is overwritten with no bubble.
- `cfg_start` arriving while `out_valid` is held: the state moves to LOAD, `in_ready` falls at the next edge, and the held output drains normally.

## Configuration
- Macro: `REFLECTOR_INVOLUTION_CHECK_EN`.
- Defined: the CHECK state and scanner are present, and wiring that is not a fixed-point-free involution produces ERR.
- Undefined: CHECK is removed, LOAD goes directly to RUN, and only the out-of-range entry error remains.

## Structure
- Shared package `reflector_pkg`:
  - State enum `refl_state_t`.
  - Default `N_SYM`, `SYM_W` and `BASE` constants.
  - `IDX_W = $clog2(N_SYM)` helper function.
- One sub-module, `refl_invol_checker`: the CHECK-state scan counter and compare. It is instantiated only under the macro.

## Test plan
- Load "YRUHQSLDPXNGOKMIEBFZCWVJAT" (check enabled) -> `cfg_done` pulses 27 cycles after the last entry. Then:
  - `in_sym` 'A', `in_inv` 0 -> `out_sym` 'Y' one cycle later.
  - 'Y' with `in_inv` 1 -> 'A'.
- Load a table whose entry 0 is 'A' (fixed point) -> `cfg_err` high at the end of CHECK, and `in_ready` stays 0.
- Load an entry of 0x5B mid-table -> ERR on the next edge; `cfg_ready` drops.
- In RUN, send `in_sym` 0x5B -> `out_sym` 0x5B with `out_err` 1.
- Stream 'A'..'Z' back-to-back with `out_ready` low for 3 cycles at 'C' -> `out_sym` holds 'U', `in_ready` is 0, and the sequence completes in order with no loss.
- Assert `reset_n` low after 10 entries of a load -> state UNCFG, all outputs 0; a fresh full load then succeeds.

Source files
------------

// File: rtl/reflector_pkg.sv
// Shared types and defaults for the parametrised reflector.
// No logic; state enum, default geometry and index-width helper.
// Used by reflector_param and refl_invol_checker.
package reflector_pkg;

    typedef enum logic [2:0] {
        ST_UNCFG = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } refl_state_t;

    localparam int         DEF_N_SYM = 26;
    localparam int         DEF_SYM_W = 8;
    localparam logic [7:0] DEF_BASE  = 8'h41;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/refl_invol_checker.sv
// Involution scanner: walks k = 0..N_SYM-1 one index per cycle while enabled.
// Latency: combinational fail/last flags for the current k.
// Backpressure: none; the counter restarts from 0 whenever i_en is low.
module refl_invol_checker
    import reflector_pkg::*;
#(
    parameter int N_SYM = DEF_N_SYM,
    parameter int IDX_W = idx_w(N_SYM)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_fwd_k,
    input  logic [IDX_W-1:0] i_fwd_fwd_k,
    output logic [IDX_W-1:0] o_k,
    output logic             o_fail,
    output logic             o_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYM - 1);

    logic [IDX_W-1:0] r_k;

    always_ff @(posedge clk) begin
        if (!reset_n || !i_en) begin
            r_k <= '0;
        end else begin
            r_k <= r_k + 1'b1;
        end
    end

    // A reflector must pair every symbol with a different one.
    assign o_k    = r_k;
    assign o_fail = (i_fwd_fwd_k != r_k) || (i_fwd_k == r_k);
    assign o_last = (r_k == LAST_IDX);

endmodule

// File: rtl/reflector_param.sv
// Runtime-loadable reflector with fwd/inv lookup; REFLECTOR_INVOLUTION_CHECK_EN adds wiring check.
// Latency: 1 cycle from input handshake to out_valid; 1 lookup per cycle.
// Backpressure: out_valid holds until out_ready; in_ready = RUN && (!out_valid || out_ready).
module reflector_param
    import reflector_pkg::*;
#(
    parameter int               N_SYM = DEF_N_SYM,
    parameter int               SYM_W = DEF_SYM_W,
    parameter logic [SYM_W-1:0] BASE  = SYM_W'(DEF_BASE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [SYM_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_err
);

    localparam int               IDX_W    = idx_w(N_SYM);
    localparam logic [SYM_W:0]   N_SYM_X  = (SYM_W + 1)'(N_SYM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYM - 1);

    refl_state_t      r_state;
    refl_state_t      w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_fwd [N_SYM];
    logic [IDX_W-1:0] r_inv [N_SYM];
    logic             r_was_run;
    logic             r_out_valid;
    logic [SYM_W-1:0] r_out_sym;
    logic             r_out_err;

    logic [SYM_W-1:0] w_d;
    logic [SYM_W-1:0] w_i;
    logic             w_d_ok;
    logic             w_i_ok;
    logic             w_cfg_fire;
    logic             w_in_fire;

    assign w_d        = cfg_data - BASE;
    assign w_d_ok     = ({1'b0, w_d} < N_SYM_X);
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_i        = in_sym - BASE;
    assign w_i_ok     = ({1'b0, w_i} < N_SYM_X);
    assign w_in_fire  = in_valid && in_ready;

`ifdef REFLECTOR_INVOLUTION_CHECK_EN
    logic [IDX_W-1:0] w_chk_k;
    logic [IDX_W-1:0] w_fwd_k;
    logic [IDX_W-1:0] w_fwd_fwd_k;
    logic             w_chk_fail;
    logic             w_chk_last;

    assign w_fwd_k     = r_fwd[w_chk_k];
    assign w_fwd_fwd_k = r_fwd[w_fwd_k];

    refl_invol_checker #(
        .N_SYM (N_SYM),
        .IDX_W (IDX_W)
    ) u_checker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_en        (r_state == ST_CHECK),
        .i_fwd_k     (w_fwd_k),
        .i_fwd_fwd_k (w_fwd_fwd_k),
        .o_k         (w_chk_k),
        .o_fail      (w_chk_fail),
        .o_last      (w_chk_last)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_UNCFG;
            r_was_run <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_was_run <= (r_state == ST_RUN);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_UNCFG, ST_RUN, ST_ERR: begin
                if (cfg_start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_cfg_fire) begin
                    if (!w_d_ok) begin
                        w_next = ST_ERR;
                    end else if (r_cnt == LAST_IDX) begin
`ifdef REFLECTOR_INVOLUTION_CHECK_EN
                        w_next = ST_CHECK;
`else
                        w_next = ST_RUN;
`endif
                    end
                end
            end
`ifdef REFLECTOR_INVOLUTION_CHECK_EN
            ST_CHECK: begin
                if (w_chk_fail)      w_next = ST_ERR;
                else if (w_chk_last) w_next = ST_RUN;
            end
`endif
            default: w_next = ST_UNCFG;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == ST_LOAD);
        cfg_err   = (r_state == ST_ERR);
        cfg_done  = (r_state == ST_RUN) && !r_was_run;
        in_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((w_next == ST_LOAD) && (r_state != ST_LOAD)) begin
            r_cnt <= '0;
        end else if (w_cfg_fire && w_d_ok) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tables hold indices; the inverse is built alongside so no second pass is needed.
    always_ff @(posedge clk) begin
        if (reset_n && w_cfg_fire && w_d_ok) begin
            r_fwd[r_cnt]            <= w_d[IDX_W-1:0];
            r_inv[w_d[IDX_W-1:0]]   <= r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            if (w_i_ok) begin
                r_out_sym <= BASE + SYM_W'(in_inv ? r_inv[w_i[IDX_W-1:0]] : r_fwd[w_i[IDX_W-1:0]]);
                r_out_err <= 1'b0;
            end else begin
                r_out_sym <= in_sym;
                r_out_err <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_reflector_param.sv
// Bench for reflector_param: table-driven lookups through a scoreboard plus load/error/reset sequences.
// Expectations for the CHECK path follow REFLECTOR_INVOLUTION_CHECK_EN as seen by this file.
module tb_reflector_param;

    localparam int N_SYM = 26;
`ifdef REFLECTOR_INVOLUTION_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, cfg_done, cfg_err;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sym = 8'h00;
    logic       in_inv = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sym;
    logic       out_err;

    reflector_param dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sym;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] sym;
        logic       inv;
        logic [7:0] exp_sym;
        logic       exp_err;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    n_pop = 0;
    int    cyc = 0;
    exp_t  q[$];
    string ukw = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    string ident = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Output side of the scoreboard: every consumed output must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", out_sym);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sym", {24'h0, out_sym}, {24'h0, e.sym});
                chk("out_err", {31'h0, out_err}, {31'h0, e.err});
                n_pop++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] s, input logic inv, input logic [7:0] es, input logic ee);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_sym   = s;
        in_inv   = inv;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                q.push_back('{sym: es, err: ee});
            end
            step();
            if (acc) break;
        end
        if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send_entries(input string s, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = s[i];
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cfg(output int lat);
        int start = cyc;
        for (int w = 0; w < 60; w++) begin
            if (cfg_done || cfg_err) break;
            step();
        end
        lat = cyc - start;
    endtask

    task automatic drain();
        for (int w = 0; w < 50; w++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        vec_t vt[9];
        int   lat;
        int   base_pop;

        vt[0] = '{8'h41, 1'b0, 8'h59, 1'b0};
        vt[1] = '{8'h59, 1'b1, 8'h41, 1'b0};
        vt[2] = '{8'h5A, 1'b0, 8'h54, 1'b0};
        vt[3] = '{8'h54, 1'b1, 8'h5A, 1'b0};
        vt[4] = '{8'h4D, 1'b1, 8'h4F, 1'b0};
        vt[5] = '{8'h42, 1'b1, 8'h52, 1'b0};
        vt[6] = '{8'h5B, 1'b0, 8'h5B, 1'b1};
        vt[7] = '{8'h40, 1'b1, 8'h40, 1'b1};
        vt[8] = '{8'h00, 1'b0, 8'h00, 1'b1};

        // Reset state
        repeat (2) step();
        chk("rst_cfg_ready", {31'h0, cfg_ready}, 0);
        chk("rst_cfg_done",  {31'h0, cfg_done},  0);
        chk("rst_cfg_err",   {31'h0, cfg_err},   0);
        chk("rst_in_ready",  {31'h0, in_ready},  0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_sym",   {24'h0, out_sym},   0);
        chk("rst_out_err",   {31'h0, out_err},   0);
        reset_n = 1'b1;
        step();

        // Full load of a valid reflector
        pulse_start();
        chk("load_cfg_ready", {31'h0, cfg_ready}, 1);
        send_entries(ukw, N_SYM);
        wait_cfg(lat);
        chk("done_latency", lat, CHK ? N_SYM : 0);
        chk("done_high", {31'h0, cfg_done}, 1);
        chk("run_in_ready", {31'h0, in_ready}, 1);
        step();
        chk("done_pulse", {31'h0, cfg_done}, 0);

        // Table-driven lookups, back-to-back
        foreach (vt[i]) send_sym(vt[i].sym, vt[i].inv, vt[i].exp_sym, vt[i].exp_err);
        in_valid = 1'b0;
        drain();

        // Stream A..Z while the consumer stalls 3 cycles on the output for 'C'
        base_pop = n_pop;
        fork
            begin
                for (int i = 0; i < N_SYM; i++) send_sym(8'(8'h41 + i), 1'b0, ukw[i], 1'b0);
                in_valid = 1'b0;
            end
            begin
                bit found = 1'b0;
                for (int w = 0; w < 100; w++) begin
                    step();
                    if (out_valid && out_sym == 8'h55) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("hold_seen", {31'h0, found}, 1);
                out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    chk("hold_out_sym",   {24'h0, out_sym},   32'h55);
                    chk("hold_in_ready",  {31'h0, in_ready},  0);
                    chk("hold_out_valid", {31'h0, out_valid}, 1);
                end
                step();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_pop - base_pop, N_SYM);

        // cfg_start while an output is held: output drains, input side closes
        out_ready = 1'b0;
        send_sym(8'h41, 1'b0, 8'h59, 1'b0);
        in_valid = 1'b0;
        pulse_start();
        chk("start_held_in_ready",  {31'h0, in_ready},  0);
        chk("start_held_cfg_ready", {31'h0, cfg_ready}, 1);
        chk("start_held_out_valid", {31'h0, out_valid}, 1);
        chk("start_held_out_sym",   {24'h0, out_sym},   32'h59);
        out_ready = 1'b1;
        step();
        chk("start_held_drained", {31'h0, out_valid}, 0);
        drain();

        // Out-of-range entry mid-table
        cfg_valid = 1'b1;
        cfg_data  = 8'h41;
        step();
        cfg_data  = 8'h42;
        step();
        cfg_data  = 8'h5B;
        step();
        cfg_valid = 1'b0;
        chk("range_cfg_err",   {31'h0, cfg_err},   1);
        chk("range_cfg_ready", {31'h0, cfg_ready}, 0);
        chk("range_in_ready",  {31'h0, in_ready},  0);

        // Fixed-point table, reloaded from ERR
        pulse_start();
        send_entries(ident, N_SYM);
        wait_cfg(lat);
        chk("fixpt_cfg_err",  {31'h0, cfg_err},  CHK ? 1 : 0);
        chk("fixpt_cfg_done", {31'h0, cfg_done}, CHK ? 0 : 1);
        step();
        chk("fixpt_in_ready", {31'h0, in_ready}, CHK ? 0 : 1);

        // Reset in the middle of a load, then a fresh load
        pulse_start();
        send_entries(ukw, 10);
        reset_n = 1'b0;
        step();
        chk("midrst_cfg_ready", {31'h0, cfg_ready}, 0);
        chk("midrst_cfg_err",   {31'h0, cfg_err},   0);
        chk("midrst_in_ready",  {31'h0, in_ready},  0);
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        chk("midrst_out_sym",   {24'h0, out_sym},   0);
        reset_n = 1'b1;
        step();
        pulse_start();
        send_entries(ukw, N_SYM);
        wait_cfg(lat);
        chk("reload_latency", lat, CHK ? N_SYM : 0);
        chk("reload_done", {31'h0, cfg_done}, 1);
        send_sym(8'h41, 1'b0, 8'h59, 1'b0);
        send_sym(8'h5B, 1'b0, 8'h5B, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
